// File: rtl/instr_loader.sv
// instr_loader: boot-stream loader. It receives a big-endian word count, then
// 4N data bytes, then an XOR checksum byte. Data bytes are written into the
// instruction RAM one byte per write. The downstream core is released only
// after the image has loaded and its checksum has matched.
module instr_loader #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  reload,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [7:0]            imem_wdata,
  output logic                  core_reset,
  output logic                  done,
  output logic                  error,
  output logic [15:0]           words_loaded
);

  // Largest word count that fits the RAM. It is kept 17 bits wide so that a
  // 16-bit header compares without overflow.
  localparam logic [16:0] MAX_WORDS = 17'((1 << ADDR_WIDTH) / 4);

  typedef enum logic [2:0] {
    S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t                  state, state_next;
  logic [7:0]              len_hi;
  logic [7:0]              csum;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic                    accept;
  logic [16:0]             len_in;
  logic                    len_bad;
  logic                    last_byte;

  assign in_ready  = (state != S_DONE) && (state != S_ERR);
  assign accept    = in_valid && in_ready;
  assign len_in    = {1'b0, len_hi, in_data};
  assign len_bad   = (len_in == 17'd0) || (len_in > MAX_WORDS);
  // The byte index of the final data byte is 4N-1. It is compared at 18 bits
  // so that N == MAX_WORDS does not alias to zero.
  assign last_byte = (18'(cnt) == ({words_loaded, 2'b00} - 18'd1));

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= S_LEN_HI;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_LEN_HI: if (accept) state_next = S_LEN_LO;
      S_LEN_LO: if (accept) state_next = len_bad ? S_ERR : S_DATA;
      S_DATA:   if (accept && last_byte) state_next = S_CSUM;
      S_CSUM:   if (accept) state_next = (in_data == csum) ? S_DONE : S_ERR;
      S_DONE,
      S_ERR:    if (reload) state_next = S_LEN_HI;
      default:  state_next = S_LEN_HI;
    endcase
  end

  // Datapath: header latch, byte counter, checksum, and the registered RAM
  // write port. The status outputs are registered from the next state so that
  // they line up with the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      len_hi       <= '0;
      words_loaded <= '0;
      cnt          <= '0;
      csum         <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      core_reset   <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      imem_we    <= 1'b0;
      core_reset <= (state_next != S_DONE);
      done       <= (state_next == S_DONE);
      error      <= (state_next == S_ERR);
      case (state)
        S_LEN_HI: if (accept) len_hi <= in_data;
        S_LEN_LO: if (accept) begin
          words_loaded <= len_in[15:0];
          cnt          <= '0;
          csum         <= '0;
        end
        S_DATA: if (accept) begin
          imem_we    <= 1'b1;
          imem_addr  <= cnt;
          imem_wdata <= in_data;
          cnt        <= cnt + 1'b1;
          csum       <= csum ^ in_data;
        end
        S_DONE,
        S_ERR: if (reload) begin
          cnt          <= '0;
          csum         <= '0;
          words_loaded <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: directed tests for instr_loader. Expected values are
// hand-computed from the stream format.
module tb_instr_loader;

  logic       clock = 1'b0;
  logic       reset, in_valid, reload;
  logic [7:0] in_data;
  logic       in_ready, imem_we, core_reset, done, error;
  logic [9:0] imem_addr;
  logic [7:0] imem_wdata;
  logic [15:0] words_loaded;

  int vecs = 0;
  int errs = 0;
  logic [7:0] img [12];

  instr_loader #(.ADDR_WIDTH(10)) dut (
    .clock(clock), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .reload(reload), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_reset(core_reset),
    .done(done), .error(error), .words_loaded(words_loaded)
  );

  always #5 clock = ~clock;

  // Advance one cycle and settle just after the edge
  task automatic tick();
    @(posedge clock); #1;
  endtask

  // Offer one byte for exactly one cycle
  task automatic feed(input logic [7:0] b);
    in_valid = 1'b1; in_data = b;
    tick();
    in_valid = 1'b0; in_data = 8'h5A;
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick();
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL rst.in_ready got=%b exp=1", in_ready); end
    vecs++; if (core_reset !== 1'b1) begin errs++; $display("FAIL rst.core_reset got=%b exp=1", core_reset); end
    vecs++; if (done !== 1'b0 || error !== 1'b0) begin errs++; $display("FAIL rst.done_err got=%b%b exp=00", done, error); end
    vecs++; if (imem_we !== 1'b0 || imem_addr !== 10'd0 || imem_wdata !== 8'h00) begin errs++; $display("FAIL rst.imem got=%b/%h/%h exp=0/000/00", imem_we, imem_addr, imem_wdata); end
    vecs++; if (words_loaded !== 16'd0) begin errs++; $display("FAIL rst.words got=%h exp=0000", words_loaded); end
    reset = 1'b0;
  endtask

  task automatic test_good_load();
    do_reset();
    feed(8'h00);
    vecs++; if (imem_we !== 1'b0) begin errs++; $display("FAIL good.hdr_we got=%b exp=0", imem_we); end
    feed(8'h03);
    vecs++; if (imem_we !== 1'b0 || in_ready !== 1'b1) begin errs++; $display("FAIL good.hdr2 we/rdy got=%b%b exp=01", imem_we, in_ready); end
    for (int k = 0; k < 12; k++) begin
      feed(img[k]);
      vecs++; if (imem_we !== 1'b1 || imem_addr !== 10'(k) || imem_wdata !== img[k]) begin errs++; $display("FAIL good.write k=%0d got=%b/%h/%h exp=1/%h/%h", k, imem_we, imem_addr, imem_wdata, k, img[k]); end
    end
    vecs++; if (in_ready !== 1'b1 || done !== 1'b0) begin errs++; $display("FAIL good.csum_state rdy/done got=%b%b exp=10", in_ready, done); end
    feed(8'hDD);
    vecs++; if (done !== 1'b1 || core_reset !== 1'b0 || error !== 1'b0) begin errs++; $display("FAIL good.done d/cr/e got=%b%b%b exp=100", done, core_reset, error); end
    vecs++; if (imem_we !== 1'b0 || in_ready !== 1'b0) begin errs++; $display("FAIL good.idle we/rdy got=%b%b exp=00", imem_we, in_ready); end
    vecs++; if (words_loaded !== 16'd3) begin errs++; $display("FAIL good.words got=%h exp=0003", words_loaded); end
  endtask

  task automatic test_bad_csum();
    do_reset();
    feed(8'h00); feed(8'h03);
    for (int k = 0; k < 12; k++) begin
      feed(img[k]);
      vecs++; if (imem_we !== 1'b1 || imem_addr !== 10'(k) || imem_wdata !== img[k]) begin errs++; $display("FAIL badcs.write k=%0d got=%b/%h/%h exp=1/%h/%h", k, imem_we, imem_addr, imem_wdata, k, img[k]); end
    end
    feed(8'h00);
    vecs++; if (error !== 1'b1 || done !== 1'b0 || core_reset !== 1'b1 || in_ready !== 1'b0) begin errs++; $display("FAIL badcs.err e/d/cr/rdy got=%b%b%b%b exp=1010", error, done, core_reset, in_ready); end
    feed(8'hDD);
    vecs++; if (imem_we !== 1'b0 || error !== 1'b1) begin errs++; $display("FAIL badcs.sticky we/e got=%b%b exp=01", imem_we, error); end
    reload = 1'b1; tick(); reload = 1'b0;
    vecs++; if (error !== 1'b0 || in_ready !== 1'b1 || words_loaded !== 16'd0) begin errs++; $display("FAIL badcs.reload e/rdy/w got=%b%b%h exp=1/0000 with e=0", error, in_ready, words_loaded); end
  endtask

  task automatic test_len_err();
    do_reset();
    feed(8'h00);
    feed(8'h00);
    vecs++; if (error !== 1'b1 || in_ready !== 1'b0 || imem_we !== 1'b0) begin errs++; $display("FAIL len0.err e/rdy/we got=%b%b%b exp=100", error, in_ready, imem_we); end
    feed(8'h11); tick();
    vecs++; if (error !== 1'b1 || core_reset !== 1'b1 || imem_we !== 1'b0) begin errs++; $display("FAIL len0.hold e/cr/we got=%b%b%b exp=110", error, core_reset, imem_we); end
    do_reset();
    feed(8'h01);
    feed(8'h01);
    vecs++; if (error !== 1'b1 || imem_we !== 1'b0 || words_loaded !== 16'h0101) begin errs++; $display("FAIL len257 e/we/w got=%b%b/%h exp=10/0101", error, imem_we, words_loaded); end
    do_reset();
    feed(8'h01);
    feed(8'h00);
    vecs++; if (error !== 1'b0 || in_ready !== 1'b1 || words_loaded !== 16'h0100) begin errs++; $display("FAIL len256 e/rdy/w got=%b%b/%h exp=01/0100", error, in_ready, words_loaded); end
  endtask

  task automatic test_toggle();
    do_reset();
    feed(8'h00); tick(); feed(8'h03); tick();
    for (int k = 0; k < 12; k++) begin
      feed(img[k]);
      vecs++; if (imem_we !== 1'b1 || imem_addr !== 10'(k) || imem_wdata !== img[k]) begin errs++; $display("FAIL tog.write k=%0d got=%b/%h/%h exp=1/%h/%h", k, imem_we, imem_addr, imem_wdata, k, img[k]); end
      in_data = 8'hEE;
      if (k == 5) reload = 1'b1;   // must be ignored mid-load
      tick();
      reload = 1'b0;
      vecs++; if (imem_we !== 1'b0 || imem_addr !== 10'(k) || imem_wdata !== img[k] || in_ready !== 1'b1) begin errs++; $display("FAIL tog.gap k=%0d got=%b/%h/%h rdy=%b exp=0/%h/%h rdy=1", k, imem_we, imem_addr, imem_wdata, in_ready, k, img[k]); end
    end
    feed(8'hDD);
    vecs++; if (done !== 1'b1 || core_reset !== 1'b0) begin errs++; $display("FAIL tog.done d/cr got=%b%b exp=10", done, core_reset); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    feed(8'h00); feed(8'h03);
    for (int k = 0; k < 5; k++) feed(img[k]);
    // Reset wins over a concurrent handshake and reload
    reset = 1'b1; in_valid = 1'b1; in_data = img[5]; reload = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0; reload = 1'b0;
    vecs++; if (imem_we !== 1'b0 || words_loaded !== 16'd0 || core_reset !== 1'b1 || in_ready !== 1'b1) begin errs++; $display("FAIL rstmid.abort we/w/cr/rdy got=%b/%h/%b%b exp=0/0000/11", imem_we, words_loaded, core_reset, in_ready); end
    feed(8'h00); feed(8'h03);
    for (int k = 0; k < 12; k++) begin
      feed(img[k]);
      vecs++; if (imem_we !== 1'b1 || imem_addr !== 10'(k) || imem_wdata !== img[k]) begin errs++; $display("FAIL rstmid.write k=%0d got=%b/%h/%h exp=1/%h/%h", k, imem_we, imem_addr, imem_wdata, k, img[k]); end
    end
    feed(8'hDD);
    vecs++; if (done !== 1'b1 || words_loaded !== 16'd3) begin errs++; $display("FAIL rstmid.done d/w got=%b/%h exp=1/0003", done, words_loaded); end
  endtask

  task automatic test_reload();
    logic [7:0] w1 [4];
    w1[0] = 8'h12; w1[1] = 8'h34; w1[2] = 8'h56; w1[3] = 8'h78;
    reload = 1'b1; tick(); reload = 1'b0;
    vecs++; if (core_reset !== 1'b1 || done !== 1'b0 || error !== 1'b0) begin errs++; $display("FAIL reload.status cr/d/e got=%b%b%b exp=100", core_reset, done, error); end
    vecs++; if (words_loaded !== 16'd0 || in_ready !== 1'b1 || imem_we !== 1'b0) begin errs++; $display("FAIL reload.clear w/rdy/we got=%h/%b%b exp=0000/10", words_loaded, in_ready, imem_we); end
    feed(8'h00); feed(8'h01);
    for (int k = 0; k < 4; k++) begin
      feed(w1[k]);
      vecs++; if (imem_we !== 1'b1 || imem_addr !== 10'(k) || imem_wdata !== w1[k]) begin errs++; $display("FAIL reload.write k=%0d got=%b/%h/%h exp=1/%h/%h", k, imem_we, imem_addr, imem_wdata, k, w1[k]); end
    end
    feed(8'h08);
    vecs++; if (done !== 1'b1 || core_reset !== 1'b0 || words_loaded !== 16'd1) begin errs++; $display("FAIL reload.done d/cr/w got=%b%b/%h exp=10/0001", done, core_reset, words_loaded); end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; reload = 1'b0;
    img[0] = 8'h00; img[1] = 8'h00; img[2]  = 8'h00; img[3]  = 8'h00;
    img[4] = 8'hFF; img[5] = 8'hA0; img[6]  = 8'h00; img[7]  = 8'h93;
    img[8] = 8'h00; img[9] = 8'h10; img[10] = 8'h22; img[11] = 8'h23;
    test_reset();
    test_good_load();
    test_bad_csum();
    test_len_err();
    test_toggle();
    test_reset_mid();
    test_reload();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
